pc_ctrl: RTL and testbench

- Program-counter and branch-resolution stage directly downstream of the ALU.
- Consumes the ALU's branch decision (doBranch) together with the decoded branch form, and produces the next instruction address for instruction memory.
- Owns the 16-entry branch lookup table used by lookup branches, the run/halt state machine and a retired-instruction counter.

---
 rtl/pc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pc_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// ----------------------------------------------------------------------------
// pc_ctrl
//
// Program-counter and branch-resolution stage. It sits directly behind the
// ALU, takes the ALU's branch decision for the current instruction and
// produces the address of the next instruction to fetch. The stage also holds:
//   - the branch lookup table used by lookup-form branches,
//   - the run/halt state machine,
//   - a saturating count of retired instructions.
//
// Parameters
//   PC_W       program counter width; addresses wrap modulo 2^PC_W (>= 8)
//   LUT_AW     lookup-table address width; table depth is 2^LUT_AW
//   START_ADDR PC value loaded on reset and on every start
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset, clears all state (LUT too)
//   start       one-cycle pulse, starts/restarts execution from IDLE or DONE
//   stall       freezes PC, counters and state for the current cycle
//   do_branch   branch-taken flag for the current instruction
//   branch_lut  0 = relative branch, 1 = lookup-table branch
//   branch_off  signed 8-bit relative branch offset
//   lut_idx     lookup-table index for lookup branches
//   halt_instr  current instruction is the final (halt) instruction
//   lut_we      lookup-table write enable
//   lut_waddr   lookup-table write address
//   lut_wdata   lookup-table write data (absolute target)
//   prog_ctr    registered current instruction address
//   fetch_en    instruction at prog_ctr executes this cycle
//   done        program has halted
//   retired     saturating count of executed instructions
//   taken_cnt   saturating count of taken branches (optional, see below)
//
// Optional feature
//   Define PC_CTRL_BRANCH_CNT_EN to add the taken_cnt output and its counter.
// ----------------------------------------------------------------------------
module pc_ctrl #(
   parameter int PC_W       = 10,
   parameter int LUT_AW     = 4,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              do_branch,
   input  logic              branch_lut,
   input  logic [7:0]        branch_off,
   input  logic [LUT_AW-1:0] lut_idx,
   input  logic              halt_instr,
   input  logic              lut_we,
   input  logic [LUT_AW-1:0] lut_waddr,
   input  logic [PC_W-1:0]   lut_wdata,
   output logic [PC_W-1:0]   prog_ctr,
   output logic              fetch_en,
   output logic              done,
   output logic [15:0]       retired
`ifdef PC_CTRL_BRANCH_CNT_EN
   ,
   output logic [15:0]       taken_cnt
`endif
);

   localparam int LUT_DEPTH = 2 ** LUT_AW;
   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state;

   logic [PC_W-1:0] lut [LUT_DEPTH];

   logic [PC_W-1:0] rel_target;
   logic [PC_W-1:0] next_pc;

   // The offset is sign-extended to the PC width, so the add wraps naturally
   // modulo 2^PC_W in both directions.
   assign rel_target = prog_ctr + {{(PC_W-8){branch_off[7]}}, branch_off};

   // An instruction executes only while running and not stalled.
   assign fetch_en = (state == RUN) && !stall;

   // Next-PC selection for a non-halting executed instruction. The LUT read
   // sees the pre-edge contents, so a same-cycle write to the same index is
   // not visible to the branch until the following cycle.
   always_comb begin
      next_pc = prog_ctr + {{(PC_W-1){1'b0}}, 1'b1};
      if (do_branch) begin
         if (branch_lut) begin
            next_pc = lut[lut_idx];
         end else begin
            next_pc = rel_target;
         end
      end
   end

   // Branch lookup table: synchronous write, accepted in any state. Reset
   // wipes every entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut[i] <= '0;
         end
      end else if (lut_we) begin
         lut[lut_waddr] <= lut_wdata;
      end
   end

   // Run/halt state machine with the PC and the counters. Start is honoured
   // only from IDLE or HALTED; a halt instruction wins over a simultaneous
   // branch and leaves the PC pointing at itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         prog_ctr  <= START_PC;
         done      <= 1'b0;
         retired   <= '0;
`ifdef PC_CTRL_BRANCH_CNT_EN
         taken_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (start) begin
                  state     <= RUN;
                  prog_ctr  <= START_PC;
                  done      <= 1'b0;
                  retired   <= '0;
`ifdef PC_CTRL_BRANCH_CNT_EN
                  taken_cnt <= '0;
`endif
               end
            end

            RUN: begin
               if (!stall) begin
                  if (retired != 16'hFFFF) begin
                     retired <= retired + 16'd1;
                  end
                  if (halt_instr) begin
                     state <= HALTED;
                     done  <= 1'b1;
                  end else begin
                     prog_ctr <= next_pc;
`ifdef PC_CTRL_BRANCH_CNT_EN
                     if (do_branch && (taken_cnt != 16'hFFFF)) begin
                        taken_cnt <= taken_cnt + 16'd1;
                     end
`endif
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_ctrl
//
// Self-checking bench for pc_ctrl: a table of directed single-cycle vectors,
// a hand-written asynchronous-reset sequence, and a randomized phase checked
// against a behavioural model of the stage.
// ----------------------------------------------------------------------------
module tb_pc_ctrl;

   localparam int PC_W   = 10;
   localparam int LUT_AW = 4;
   localparam int PC_MOD = 1 << PC_W;

   logic              clk;
   logic              reset;
   logic              start;
   logic              stall;
   logic              do_branch;
   logic              branch_lut;
   logic [7:0]        branch_off;
   logic [LUT_AW-1:0] lut_idx;
   logic              halt_instr;
   logic              lut_we;
   logic [LUT_AW-1:0] lut_waddr;
   logic [PC_W-1:0]   lut_wdata;
   logic [PC_W-1:0]   prog_ctr;
   logic              fetch_en;
   logic              done;
   logic [15:0]       retired;
   logic [15:0]       taken_cnt;

   int n_checks;
   int n_fail;

   // Behavioural model state
   bit m_running;
   bit m_done;
   int m_pc;
   int m_retired;
   int m_taken;
   int m_lut [16];

   typedef struct {
      logic        start;
      logic        stall;
      logic        br;
      logic        blut;
      logic [7:0]  off;
      logic [3:0]  idx;
      logic        halt;
      logic        we;
      logic [3:0]  waddr;
      logic [9:0]  wdata;
      logic        exp_fetch;
      int          exp_pc;
      logic        exp_done;
      int          exp_ret;
      int          exp_taken;
   } vec_t;

   vec_t tbl[$];

   pc_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .START_ADDR(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stall      (stall),
      .do_branch  (do_branch),
      .branch_lut (branch_lut),
      .branch_off (branch_off),
      .lut_idx    (lut_idx),
      .halt_instr (halt_instr),
      .lut_we     (lut_we),
      .lut_waddr  (lut_waddr),
      .lut_wdata  (lut_wdata),
      .prog_ctr   (prog_ctr),
      .fetch_en   (fetch_en),
      .done       (done),
      .retired    (retired)
`ifdef PC_CTRL_BRANCH_CNT_EN
      ,
      .taken_cnt  (taken_cnt)
`endif
   );

`ifndef PC_CTRL_BRANCH_CNT_EN
   assign taken_cnt = '0;
`endif

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t row(
      input logic start_v, input logic stall_v, input logic br_v,
      input logic blut_v, input logic [7:0] off_v, input logic [3:0] idx_v,
      input logic halt_v, input logic we_v, input logic [3:0] waddr_v,
      input logic [9:0] wdata_v, input logic fetch_v, input int pc_v,
      input logic done_v, input int ret_v, input int taken_v);
      vec_t v;
      v.start = start_v;  v.stall = stall_v; v.br = br_v; v.blut = blut_v;
      v.off = off_v;      v.idx = idx_v;     v.halt = halt_v;
      v.we = we_v;        v.waddr = waddr_v; v.wdata = wdata_v;
      v.exp_fetch = fetch_v; v.exp_pc = pc_v; v.exp_done = done_v;
      v.exp_ret = ret_v;  v.exp_taken = taken_v;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      start      = v.start;
      stall      = v.stall;
      do_branch  = v.br;
      branch_lut = v.blut;
      branch_off = v.off;
      lut_idx    = v.idx;
      halt_instr = v.halt;
      lut_we     = v.we;
      lut_waddr  = v.waddr;
      lut_wdata  = v.wdata;
   endtask

   task automatic idleInputs();
      vec_t v;
      v = row(0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 4'h0, 10'h000, 0, 0, 0, 0, 0);
      applyStimulus(v);
   endtask

   // One directed cycle: drive at the falling edge, check fetch_en before the
   // rising edge and the registered outputs just after it.
   task automatic runVector(input string tag, input vec_t v);
      @(negedge clk);
      applyStimulus(v);
      #1;
      checkOutput({tag, ".fetch_en"}, 32'(fetch_en), 32'(v.exp_fetch));
      @(posedge clk);
      #1;
      checkOutput({tag, ".prog_ctr"}, 32'(prog_ctr), 32'(v.exp_pc));
      checkOutput({tag, ".done"}, 32'(done), 32'(v.exp_done));
      checkOutput({tag, ".retired"}, 32'(retired), 32'(v.exp_ret));
`ifdef PC_CTRL_BRANCH_CNT_EN
      checkOutput({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(v.exp_taken));
`endif
   endtask

   task automatic doReset();
      @(negedge clk);
      idleInputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_running = 0; m_done = 0; m_pc = 0; m_retired = 0; m_taken = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
   endtask

   // Model of one rising edge, written from the stage's rules.
   task automatic modelEdge();
      int off;
      bit fe;
      fe = m_running && !stall;
      if (fe) begin
         if (m_retired < 65535) m_retired++;
         if (halt_instr) begin
            m_running = 0;
            m_done    = 1;
         end else if (do_branch) begin
            if (m_taken < 65535) m_taken++;
            if (branch_lut) begin
               m_pc = m_lut[lut_idx];
            end else begin
               off  = int'($signed(branch_off));
               m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
            end
         end else begin
            m_pc = (m_pc + 1) % PC_MOD;
         end
      end else if (!m_running && start) begin
         m_running = 1; m_done = 0; m_pc = 0; m_retired = 0; m_taken = 0;
      end
      if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
   endtask

   initial begin
      vec_t v;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idleInputs();

      // Reset values while reset is held
      #2;
      checkOutput("reset.prog_ctr", 32'(prog_ctr), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.retired", 32'(retired), 32'd0);
      checkOutput("reset.fetch_en", 32'(fetch_en), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Directed table: start+LUT write, straight-line run, relative branches
      // (incl. wrap below zero), lookup branches, same-cycle LUT write/read,
      // 0x3FF->0 wrap, stall, halt beating branch, DONE hold, restart, and
      // start ignored while running.
      tbl.push_back(row(1,0,0,0,8'h00,4'd0,0,1,4'd3,10'h155, 0,0,0,0,0));
      for (int i = 1; i <= 5; i++)
         tbl.push_back(row(0,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 1,i,0,i,0));
      tbl.push_back(row(0,0,1,0,8'h0F,4'd0,0,0,4'd0,10'h000, 1,20,0,6,1));
      tbl.push_back(row(0,0,1,0,8'hFB,4'd0,0,0,4'd0,10'h000, 1,15,0,7,2));
      tbl.push_back(row(0,0,1,0,8'hF8,4'd0,0,0,4'd0,10'h000, 1,7,0,8,3));
      tbl.push_back(row(0,0,1,1,8'h00,4'd3,0,0,4'd0,10'h000, 1,'h155,0,9,4));
      tbl.push_back(row(0,0,1,1,8'h00,4'd3,0,1,4'd3,10'h0AA, 1,'h155,0,10,5));
      tbl.push_back(row(0,0,1,1,8'h00,4'd3,0,1,4'd5,10'h002, 1,'h0AA,0,11,6));
      tbl.push_back(row(0,0,1,1,8'h00,4'd5,0,0,4'd0,10'h000, 1,2,0,12,7));
      tbl.push_back(row(0,0,1,0,8'hFC,4'd0,0,0,4'd0,10'h000, 1,1022,0,13,8));
      tbl.push_back(row(0,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 1,1023,0,14,8));
      tbl.push_back(row(0,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 1,0,0,15,8));
      tbl.push_back(row(0,0,1,0,8'h09,4'd0,0,0,4'd0,10'h000, 1,9,0,16,9));
      for (int i = 0; i < 3; i++)
         tbl.push_back(row(0,1,1,0,8'h05,4'd0,0,0,4'd0,10'h000, 0,9,0,16,9));
      tbl.push_back(row(0,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 1,10,0,17,9));
      tbl.push_back(row(0,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 1,11,0,18,9));
      tbl.push_back(row(0,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 1,12,0,19,9));
      tbl.push_back(row(0,0,1,0,8'h05,4'd0,1,0,4'd0,10'h000, 1,12,1,20,9));
      tbl.push_back(row(0,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 0,12,1,20,9));
      tbl.push_back(row(0,0,1,0,8'h05,4'd0,0,0,4'd0,10'h000, 0,12,1,20,9));
      tbl.push_back(row(1,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 0,0,0,0,0));
      tbl.push_back(row(1,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 1,1,0,1,0));

      foreach (tbl[i]) begin
         runVector($sformatf("vec%0d", i), tbl[i]);
      end

      // Three taken branches up to PC 40, then reset mid-run between edges.
      for (int i = 1; i <= 3; i++) begin
         v = row(0,0,1,0,8'h0D,4'd0,0,0,4'd0,10'h000, 1,1+13*i,0,1+i,i);
         runVector($sformatf("pre_reset%0d", i), v);
      end
      @(negedge clk);
      idleInputs();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset.prog_ctr", 32'(prog_ctr), 32'd0);
      checkOutput("async_reset.done", 32'(done), 32'd0);
      checkOutput("async_reset.retired", 32'(retired), 32'd0);
      checkOutput("async_reset.fetch_en", 32'(fetch_en), 32'd0);
`ifdef PC_CTRL_BRANCH_CNT_EN
      checkOutput("async_reset.taken_cnt", 32'(taken_cnt), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // LUT contents were lost: lookup branch through entry 3 lands on 0.
      runVector("post_reset_start", row(1,0,0,0,8'h00,4'd0,0,0,4'd0,10'h000, 0,0,0,0,0));
      runVector("post_reset_lut", row(0,0,1,1,8'h00,4'd3,0,0,4'd0,10'h000, 1,0,0,1,1));

      // Randomized phase against the behavioural model.
      doReset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         start      = ($urandom_range(0, 7) == 0);
         stall      = ($urandom_range(0, 3) == 0);
         do_branch  = ($urandom_range(0, 9) < 3);
         branch_lut = 1'($urandom_range(0, 1));
         branch_off = 8'($urandom);
         lut_idx    = 4'($urandom);
         halt_instr = ($urandom_range(0, 15) == 0);
         lut_we     = ($urandom_range(0, 9) < 3);
         lut_waddr  = 4'($urandom);
         lut_wdata  = 10'($urandom);
         #1;
         checkOutput("rand.fetch_en", 32'(fetch_en), 32'(m_running && !stall));
         @(posedge clk);
         modelEdge();
         #1;
         checkOutput("rand.prog_ctr", 32'(prog_ctr), 32'(m_pc));
         checkOutput("rand.done", 32'(done), 32'(m_done));
         checkOutput("rand.retired", 32'(retired), 32'(m_retired));
`ifdef PC_CTRL_BRANCH_CNT_EN
         checkOutput("rand.taken_cnt", 32'(taken_cnt), 32'(m_taken));
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
